// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_pkg                                                 |
// | Brief   : UART state encodings and parity constants for TX and RX  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_state_w-1:0] c_st_start  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_data   = 3'd2;
    localparam logic [c_state_w-1:0] c_st_parity = 3'd3;
    localparam logic [c_state_w-1:0] c_st_stop   = 3'd4;

    localparam logic c_par_even = 1'b0;
    localparam logic c_par_odd  = 1'b1;

    // data_xor is the XOR reduction of the data word.
    function automatic logic parity_bit(input logic data_xor, input logic par_type);
        return (par_type == c_par_odd) ? ~data_xor : data_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_baud_gen                                            |
// | Brief   : Prescale counter; bit_end marks the last cycle of a bit  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_baud_gen #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] r_count;

    assign bit_end = run && (r_count == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!run || bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_tx_cfg                                              |
// | Brief   : UART transmitter, configurable width/parity/stop/baud    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_enable,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  s_data,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int                 c_cnt_w    = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

    logic [c_state_w-1:0]  r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [c_cnt_w-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_stop_second, w_stop_second_nxt;
    logic                  r_s_data, w_s_data_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_tx_done, w_tx_done_nxt;
    logic                  w_accept;

    // Frame configuration captured at accept; the parity bit is resolved
    // then because the shift register no longer holds the whole word later.
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic [PRESCALE_W-1:0] r_prescale;

    logic w_run;
    logic w_bit_end;

    assign w_run = (r_state != c_st_idle);

    uart_baud_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (w_run),
        .prescale (r_prescale),
        .bit_end  (w_bit_end)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_stop_second_nxt = r_stop_second;
        w_s_data_nxt      = r_s_data;
        w_busy_nxt        = r_busy;
        w_tx_done_nxt     = 1'b0;
        w_accept          = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_s_data_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (data_valid) begin
                    w_accept          = 1'b1;
                    w_state_nxt       = c_st_start;
                    w_s_data_nxt      = 1'b0;
                    w_busy_nxt        = 1'b1;
                    w_shift_nxt       = p_data;
                    w_bit_cnt_nxt     = '0;
                    w_stop_second_nxt = 1'b0;
                end
            end
            c_st_start: begin
                if (w_bit_end) begin
                    w_state_nxt  = c_st_data;
                    w_s_data_nxt = r_shift[0];
                end
            end
            c_st_data: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_last_bit) begin
                        if (r_par_en) begin
                            w_state_nxt  = c_st_parity;
                            w_s_data_nxt = r_par_bit;
                        end else begin
                            w_state_nxt  = c_st_stop;
                            w_s_data_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                        w_s_data_nxt  = r_shift[1];
                    end
                end
            end
            c_st_parity: begin
                if (w_bit_end) begin
                    w_state_nxt  = c_st_stop;
                    w_s_data_nxt = 1'b1;
                end
            end
            c_st_stop: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_stop_second_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = c_st_idle;
                        w_busy_nxt    = 1'b0;
                        w_tx_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = c_st_idle;
                w_s_data_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_stop_second <= 1'b0;
            r_s_data      <= 1'b1;
            r_busy        <= 1'b0;
            r_tx_done     <= 1'b0;
            r_par_en      <= 1'b0;
            r_par_bit     <= c_par_even;
            r_stop2       <= 1'b0;
            r_prescale    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_stop_second <= w_stop_second_nxt;
            r_s_data      <= w_s_data_nxt;
            r_busy        <= w_busy_nxt;
            r_tx_done     <= w_tx_done_nxt;
            if (w_accept) begin
                r_par_en   <= par_enable;
                r_par_bit  <= parity_bit(^p_data, par_type);
                r_stop2    <= stop2;
                r_prescale <= prescale;
            end
        end
    end

    assign s_data  = r_s_data;
    assign busy    = r_busy;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_uart_tx_cfg                                           |
// | Brief   : Self-checking bench, frame-level model for 8 and 7 bits  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] d8_p_data, d8_presc;
    logic       d8_valid, d8_pe, d8_pt, d8_s2, d8_s, d8_busy, d8_done;
    logic [6:0] d7_p_data;
    logic [7:0] d7_presc;
    logic       d7_valid, d7_pe, d7_pt, d7_s2, d7_s, d7_busy, d7_done;

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .p_data(d8_p_data), .data_valid(d8_valid),
        .par_enable(d8_pe), .par_type(d8_pt), .stop2(d8_s2), .prescale(d8_presc),
        .s_data(d8_s), .busy(d8_busy), .tx_done(d8_done)
    );

    uart_tx_cfg #(.DATA_WIDTH(7), .PRESCALE_W(8)) u_dut7 (
        .clk(clk), .rst(rst), .p_data(d7_p_data), .data_valid(d7_valid),
        .par_enable(d7_pe), .par_type(d7_pt), .stop2(d7_s2), .prescale(d7_presc),
        .s_data(d7_s), .busy(d7_busy), .tx_done(d7_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line levels of one frame in bit order: start, data LSB first, parity, stops.
    function automatic void frame_bits(input logic [8:0] d, input int w, input logic pe,
                                       input logic pt, input logic s2,
                                       output logic [15:0] bits, output int n);
        int ones;
        ones = 0;
        n    = 0;
        bits = '0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < w; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pe) begin
            bits[n] = pt ? (ones % 2 == 0) : (ones % 2 == 1);
            n++;
        end
        bits[n] = 1'b1; n++;
        if (s2) begin
            bits[n] = 1'b1; n++;
        end
    endfunction

    // Expected {s_data, busy, tx_done} for the cycle after each rising edge.
    logic [2:0] q8[$];
    logic [2:0] q7[$];
    logic [2:0] e8 = 3'b100;
    logic [2:0] e7 = 3'b100;

    initial forever begin : model8
        logic [15:0] bits;
        int          n;
        @(posedge clk or posedge rst);
        if (rst) begin
            q8.delete();
            e8 = 3'b100;
        end else begin
            if (q8.size() == 0 && d8_valid) begin
                frame_bits({1'b0, d8_p_data}, 8, d8_pe, d8_pt, d8_s2, bits, n);
                for (int k = 0; k < n; k++)
                    for (int c = 0; c <= int'(d8_presc); c++)
                        q8.push_back({bits[k], 1'b1, 1'b0});
                q8.push_back(3'b101);
            end
            e8 = (q8.size() != 0) ? q8.pop_front() : 3'b100;
        end
    end

    initial forever begin : model7
        logic [15:0] bits;
        int          n;
        @(posedge clk or posedge rst);
        if (rst) begin
            q7.delete();
            e7 = 3'b100;
        end else begin
            if (q7.size() == 0 && d7_valid) begin
                frame_bits({2'b00, d7_p_data}, 7, d7_pe, d7_pt, d7_s2, bits, n);
                for (int k = 0; k < n; k++)
                    for (int c = 0; c <= int'(d7_presc); c++)
                        q7.push_back({bits[k], 1'b1, 1'b0});
                q7.push_back(3'b101);
            end
            e7 = (q7.size() != 0) ? q7.pop_front() : 3'b100;
        end
    end

    int done8_cnt = 0;

    initial forever begin : compare
        @(negedge clk);
        check("dut8_line_busy_done", {29'd0, d8_s, d8_busy, d8_done}, {29'd0, e8});
        check("dut7_line_busy_done", {29'd0, d7_s, d7_busy, d7_done}, {29'd0, e7});
        if (d8_done === 1'b1) done8_cnt++;
    end

    logic [0:199] rec;
    int           rec_n;
    logic         done_after;

    // Sends one frame and records the line level on every busy cycle.
    task automatic run_frame(input bit use7, input logic [8:0] d, input logic pe,
                             input logic pt, input logic s2, input logic [7:0] presc,
                             input bit perturb);
        int   guard;
        logic bsy;
        @(negedge clk);
        if (use7) begin
            d7_p_data = d[6:0]; d7_pe = pe; d7_pt = pt; d7_s2 = s2;
            d7_presc = presc; d7_valid = 1'b1;
        end else begin
            d8_p_data = d[7:0]; d8_pe = pe; d8_pt = pt; d8_s2 = s2;
            d8_presc = presc; d8_valid = 1'b1;
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            bsy = use7 ? d7_busy : d8_busy;
        end while (!bsy && guard < 20);
        check("frame_start", {31'd0, bsy}, 32'd1);
        d7_valid = 1'b0;
        d8_valid = 1'b0;
        if (perturb) begin
            d8_p_data = 8'hFF; d8_presc = 8'd5; d8_pt = ~pt; d8_s2 = ~s2; d8_pe = ~pe;
            d7_p_data = 7'h7F; d7_presc = 8'd5; d7_pt = ~pt; d7_s2 = ~s2; d7_pe = ~pe;
        end
        rec   = '0;
        rec_n = 0;
        while (bsy && rec_n < 200) begin
            rec[rec_n] = use7 ? d7_s : d8_s;
            rec_n++;
            @(negedge clk);
            bsy = use7 ? d7_busy : d8_busy;
        end
        check("frame_end", {31'd0, bsy}, 32'd0);
        done_after = use7 ? d7_done : d8_done;
    endtask

    task automatic wait_busy8(input logic lvl);
        int g;
        g = 0;
        while (d8_busy !== lvl && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("wait_busy8", {31'd0, d8_busy}, {31'd0, lvl});
    endtask

    initial begin : stimulus
        logic [0:10] pat1;
        logic [0:8]  pat3;
        int          gap;
        int          busy_seen;
        int          done_base;

        pat1 = 11'b01010010101;
        pat3 = 9'b010101011;

        rst = 1'b1;
        d8_p_data = '0; d8_presc = '0; d8_valid = 0; d8_pe = 0; d8_pt = 0; d8_s2 = 0;
        d7_p_data = '0; d7_presc = '0; d7_valid = 0; d7_pe = 0; d7_pt = 0; d7_s2 = 0;
        repeat (3) @(negedge clk);
        check("reset_s_data", {31'd0, d8_s}, 32'd1);
        check("reset_busy", {31'd0, d8_busy}, 32'd0);
        check("reset_tx_done", {31'd0, d8_done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, even parity, one stop, 1 cycle per bit
        run_frame(0, 9'h0A5, 1'b1, c_par_even, 1'b0, 8'd0, 0);
        check("t1_len", rec_n, 32'd11);
        check("t1_serial", {21'd0, rec[0:10]}, {21'd0, pat1});
        check("t1_done_pulse", {31'd0, done_after}, 32'd1);

        // 0x01, odd parity, two stops, 4 cycles per bit
        run_frame(0, 9'h001, 1'b1, c_par_odd, 1'b1, 8'd3, 0);
        check("t2_busy_cycles", rec_n, 32'd48);
        check("t2_start", {28'd0, rec[0:3]}, 32'h0);
        check("t2_bit0", {28'd0, rec[4:7]}, 32'hF);
        check("t2_parity", {28'd0, rec[36:39]}, 32'h0);
        check("t2_stop", {24'd0, rec[40:47]}, 32'hFF);

        // 7-bit instance, no parity
        run_frame(1, 9'h055, 1'b0, c_par_even, 1'b0, 8'd0, 0);
        check("t3_len", rec_n, 32'd9);
        check("t3_serial", {23'd0, rec[0:8]}, {23'd0, pat3});

        // Valid held: 0x3C then 0xC3 back to back, then a stray mid-frame pulse
        done_base = done8_cnt;
        @(negedge clk);
        d8_p_data = 8'h3C; d8_pe = 0; d8_s2 = 0; d8_presc = 8'd0; d8_valid = 1'b1;
        wait_busy8(1'b1);
        d8_p_data = 8'hC3;
        wait_busy8(1'b0);
        gap = 0;
        while (!d8_busy && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("t4_idle_gap", gap, 32'd1);
        d8_valid = 1'b0;
        repeat (3) @(negedge clk);
        d8_valid = 1'b1;
        @(negedge clk);
        d8_valid = 1'b0;
        wait_busy8(1'b0);
        busy_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (d8_busy) busy_seen++;
        end
        check("t4_no_extra_frame", busy_seen, 32'd0);
        check("t4_done_pulses", done8_cnt - done_base, 32'd2);

        // Asynchronous reset in the middle of a data bit
        @(negedge clk);
        d8_p_data = 8'h00; d8_pe = 0; d8_s2 = 0; d8_presc = 8'd3; d8_valid = 1'b1;
        @(negedge clk);
        wait_busy8(1'b1);
        d8_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_line_low_before_rst", {31'd0, d8_s}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_s_data", {31'd0, d8_s}, 32'd1);
        check("t5_rst_busy", {31'd0, d8_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 9'h096, 1'b1, c_par_odd, 1'b0, 8'd1, 0);
        check("t5_clean_len", rec_n, 32'd22);

        // Inputs disturbed after accept must not alter the frame
        run_frame(0, 9'h05A, 1'b1, c_par_even, 1'b0, 8'd1, 1);
        check("t6_len", rec_n, 32'd22);
        check("t6_parity", {30'd0, rec[18:19]}, 32'd0);
        run_frame(1, 9'h033, 1'b1, c_par_odd, 1'b1, 8'd2, 1);
        check("t6_len7", rec_n, 32'd33);

        // Randomised traffic on both instances, with one reset in the middle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                d8_p_data = 8'($urandom);
                d8_pe     = 1'($urandom_range(0, 1));
                d8_pt     = 1'($urandom_range(0, 1));
                d8_s2     = 1'($urandom_range(0, 1));
                d8_presc  = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                d7_p_data = 7'($urandom);
                d7_pe     = 1'($urandom_range(0, 1));
                d7_pt     = 1'($urandom_range(0, 1));
                d7_s2     = 1'($urandom_range(0, 1));
                d7_presc  = 8'($urandom_range(0, 2));
            end
            d8_valid = ($urandom_range(0, 5) == 0);
            d7_valid = ($urandom_range(0, 2) == 0);
            if (cyc == 1777) #1 rst = 1'b1;
            if (cyc == 1778) #1 rst = 1'b0;
        end
        d8_valid = 1'b0;
        d7_valid = 1'b0;
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
